// File: rtl/bt_axi_host_if.sv
// bt_axi_host_if: AXI4-Lite host end of the Bluetooth UART byte interface.
// Holds received bytes in a small RX FIFO and turns TX_DATA register writes
// into single-cycle pushes to the TX character FIFO. Keeps sticky
// overrun/drop flags and drives a level interrupt. Single clock domain (clk_rx).
module bt_axi_host_if #(
    parameter int RX_DEPTH = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk_rx,
    input  logic        rst_clk_rx_n,
    // write address / data / response
    input  logic [3:0]  s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    // read address / data
    input  logic [3:0]  s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    // UART byte interface
    input  logic [7:0]  rx_data,
    input  logic        rx_buf_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_buf_en,
    input  logic        tx_buf_full,
    output logic        irq
);
    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0] rx_count;
    logic             rx_overrun, tx_drop, irq_en;

    logic             wr_hs, rd_hs, ctrl_wr, tx_wr, flush;
    logic             rx_empty, rx_full, pop, push, ov_set, drop_set;
    logic [1:0]       wr_sel, rd_sel;
    logic [31:0]      rd_word;

    // Ready outputs are combinational but forced low while reset is held.
    assign wr_hs         = rst_clk_rx_n & s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
    assign s_axi_awready = wr_hs;
    assign s_axi_wready  = wr_hs;
    assign s_axi_arready = rst_clk_rx_n & ~s_axi_rvalid;
    assign rd_hs         = s_axi_arvalid & s_axi_arready;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;

    assign wr_sel   = s_axi_awaddr[3:2];
    assign rd_sel   = s_axi_araddr[3:2];
    assign ctrl_wr  = wr_hs & (wr_sel == 2'd3);
    assign tx_wr    = wr_hs & (wr_sel == 2'd1) & s_axi_wstrb[0];
    assign flush    = ctrl_wr & s_axi_wdata[2];

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CNT_W'(RX_DEPTH));
    // A pop frees a slot this cycle, so a push into a full FIFO still lands.
    // Flush overrides both and swallows a coincident push without flagging it.
    assign pop      = rd_hs & (rd_sel == 2'd0) & ~rx_empty;
    assign push     = rx_buf_rdy & (~rx_full | pop) & ~flush;
    assign ov_set   = rx_buf_rdy & rx_full & ~pop & ~flush;
    assign drop_set = tx_wr & tx_buf_full;

    // Register read mux, evaluated against the pre-update state.
    always_comb begin
        rd_word = '0;
        case (rd_sel)
            2'd0: rd_word = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_mem[rd_ptr]};
            2'd1: rd_word = 32'd0;
            2'd2: rd_word = 32'({rx_count, 3'b000, tx_drop, rx_overrun,
                                 tx_buf_full, rx_full, ~rx_empty});
            default: rd_word = {28'd0, irq_en, 3'b000};
        endcase
    end

    // Write response: one beat per accepted write, held until bready.
    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n)      s_axi_bvalid <= 1'b0;
        else if (wr_hs)         s_axi_bvalid <= 1'b1;
        else if (s_axi_bready)  s_axi_bvalid <= 1'b0;
    end

    // Read data capture; rdata stays stable while rvalid waits for rready.
    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else if (rd_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_word;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    // RX FIFO storage; no reset needed, validity is tracked by rx_count.
    always_ff @(posedge clk_rx) begin
        if (push) rx_mem[wr_ptr] <= rx_data;
    end

    // RX FIFO pointers and occupancy; pointers wrap naturally at RX_DEPTH.
    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            rx_count <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      rx_count <= rx_count + CNT_W'(1);
            else if (pop && !push) rx_count <= rx_count - CNT_W'(1);
        end
    end

    // Sticky status and control; a set wins over a same-cycle clear.
    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            rx_overrun <= ov_set   | (rx_overrun & ~(ctrl_wr & s_axi_wdata[0]));
            tx_drop    <= drop_set | (tx_drop    & ~(ctrl_wr & s_axi_wdata[1]));
            if (ctrl_wr) irq_en <= s_axi_wdata[3];
        end
    end

    // TX push pulse and level interrupt.
    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            tx_data   <= '0;
            tx_buf_en <= 1'b0;
            irq       <= 1'b0;
        end else begin
            tx_buf_en <= tx_wr & ~tx_buf_full;
            if (tx_wr && !tx_buf_full) tx_data <= s_axi_wdata[7:0];
            irq <= irq_en & ~rx_empty;
        end
    end

    // Address LSBs, upper data bits and upper strobes carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata[31:8], s_axi_wstrb[3:1]};

endmodule

// File: tb/tb_bt_axi_host_if.sv
// Bench for bt_axi_host_if: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_bt_axi_host_if;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic        clk_rx = 1'b0;
    logic        rst_clk_rx_n = 1'b0;
    logic [3:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [3:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_buf_rdy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_buf_en;
    logic        tx_buf_full = 1'b0;
    logic        irq;

    bt_axi_host_if #(.RX_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_rx(clk_rx), .rst_clk_rx_n(rst_clk_rx_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .rx_data(rx_data), .rx_buf_rdy(rx_buf_rdy), .tx_data(tx_data), .tx_buf_en(tx_buf_en),
        .tx_buf_full(tx_buf_full), .irq(irq)
    );

    always #5 clk_rx = ~clk_rx;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned q[$];
    bit          m_ov, m_drop, m_irq_en, m_bpend, m_rpend, m_txen, m_irq;
    logic [31:0] m_rdata;
    logic [7:0]  m_txd;

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_drop = 0; m_irq_en = 0; m_bpend = 0; m_rpend = 0;
        m_txen = 0; m_irq = 0; m_rdata = '0; m_txd = '0;
    endtask

    task automatic model_step();
        bit wr_hs, rd_hs, pop, flush, ov_set, drop_set, clr_ov, clr_drop, irq_nxt;
        int sz;
        wr_hs = s_axi_awvalid && s_axi_wvalid && !m_bpend;
        rd_hs = s_axi_arvalid && !m_rpend;
        sz = q.size();
        irq_nxt = m_irq_en && (sz > 0);
        flush = 0; ov_set = 0; drop_set = 0; clr_ov = 0; clr_drop = 0;
        if (rd_hs) begin
            case (s_axi_araddr[3:2])
                2'd0: m_rdata = (sz > 0) ? (32'h100 | 32'(q[0])) : 32'd0;
                2'd1: m_rdata = 32'd0;
                2'd2: m_rdata = 32'(sz) * 256 + 32'(m_drop) * 16 + 32'(m_ov) * 8
                              + 32'(tx_buf_full) * 4 + 32'(sz == DEPTH) * 2 + 32'(sz > 0);
                default: m_rdata = 32'(m_irq_en) * 8;
            endcase
            m_rpend = 1;
        end else if (m_rpend && s_axi_rready) begin
            m_rpend = 0;
        end
        pop = rd_hs && (s_axi_araddr[3:2] == 2'd0) && (sz > 0);
        m_txen = 0;
        if (wr_hs) begin
            m_bpend = 1;
            if (s_axi_awaddr[3:2] == 2'd1 && s_axi_wstrb[0]) begin
                if (tx_buf_full) drop_set = 1;
                else begin m_txen = 1; m_txd = s_axi_wdata[7:0]; end
            end
            if (s_axi_awaddr[3:2] == 2'd3) begin
                clr_ov = s_axi_wdata[0]; clr_drop = s_axi_wdata[1];
                flush = s_axi_wdata[2]; m_irq_en = s_axi_wdata[3];
            end
        end else if (m_bpend && s_axi_bready) begin
            m_bpend = 0;
        end
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (rx_buf_rdy) begin
                if (sz < DEPTH || pop) q.push_back(rx_data);
                else ov_set = 1;
            end
        end
        m_ov   = ov_set   || (m_ov   && !clr_ov);
        m_drop = drop_set || (m_drop && !clr_drop);
        m_irq  = irq_nxt;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_rx or negedge rst_clk_rx_n);
            if (!rst_clk_rx_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk_rx);
            #2;
            chk("awready", s_axi_awready, rst_clk_rx_n && s_axi_awvalid && s_axi_wvalid && !m_bpend);
            chk("wready",  s_axi_wready,  rst_clk_rx_n && s_axi_awvalid && s_axi_wvalid && !m_bpend);
            chk("arready", s_axi_arready, rst_clk_rx_n && !m_rpend);
            chk("bvalid",  s_axi_bvalid, m_bpend);
            chk("rvalid",  s_axi_rvalid, m_rpend);
            chk("rdata",   s_axi_rdata, m_rdata);
            chk("resp",    {s_axi_bresp, s_axi_rresp}, 4'h0);
            chk("tx_en",   tx_buf_en, m_txen);
            chk("tx_data", tx_data, m_txd);
            chk("irq",     irq, m_irq);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk_rx);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(negedge clk_rx);
        s_axi_awvalid = 0; s_axi_wvalid = 0;
    endtask

    task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk_rx);
        s_axi_araddr = a; s_axi_arvalid = 1;
        @(negedge clk_rx);
        s_axi_arvalid = 0;
        d = s_axi_rdata;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk_rx);
        rx_data = b; rx_buf_rdy = 1;
        @(negedge clk_rx);
        rx_buf_rdy = 0;
    endtask

    logic [31:0] d, d0;

    initial begin
        // reset state
        repeat (3) @(negedge clk_rx);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_tx_en",  tx_buf_en, 0);
        chk("rst_irq",    irq, 0);
        rst_clk_rx_n = 1;

        // RX path
        rx_byte(8'h41); rx_byte(8'h42);
        axi_rd(4'h8, d); chk("rx_cnt2", (d >> 8) & 32'h1F, 2);
        axi_rd(4'h0, d); chk("rx_b0", d, 32'h141);
        axi_rd(4'h0, d); chk("rx_b1", d, 32'h142);
        axi_rd(4'h0, d); chk("rx_empty", d, 32'h0);
        axi_rd(4'h8, d); chk("rx_cnt0", (d >> 8) & 32'h1F, 0);

        // overrun
        for (int i = 0; i < 17; i++) rx_byte(8'(i));
        axi_rd(4'h8, d); chk("ov_full", d[1], 1); chk("ov_flag", d[3], 1);
        for (int i = 0; i < 16; i++) begin
            axi_rd(4'h0, d); chk("ov_data", d, 32'h100 + 32'(i));
        end
        axi_wr(4'hC, 32'h1, 4'hF);
        axi_rd(4'h8, d); chk("ov_clr", d[3], 0);

        // full FIFO, simultaneous push and pop
        for (int i = 0; i < 16; i++) rx_byte(8'h60 + 8'(i));
        @(negedge clk_rx);
        s_axi_araddr = 4'h0; s_axi_arvalid = 1; rx_data = 8'h55; rx_buf_rdy = 1;
        @(negedge clk_rx);
        s_axi_arvalid = 0; rx_buf_rdy = 0;
        chk("pp_head", s_axi_rdata, 32'h160);
        axi_rd(4'h8, d); chk("pp_cnt", (d >> 8) & 32'h1F, 16); chk("pp_noov", d[3], 0);
        for (int i = 1; i < 16; i++) begin
            axi_rd(4'h0, d); chk("pp_data", d, 32'h160 + 32'(i));
        end
        axi_rd(4'h0, d); chk("pp_last", d, 32'h155);

        // TX path
        axi_wr(4'h4, 32'h5A, 4'hF);
        chk("tx_pulse", tx_buf_en, 1); chk("tx_byte", tx_data, 8'h5A);
        @(negedge clk_rx); chk("tx_once", tx_buf_en, 0);
        axi_wr(4'h4, 32'h33, 4'hE);
        chk("tx_nostrb", tx_buf_en, 0);
        tx_buf_full = 1;
        axi_wr(4'h4, 32'hA5, 4'hF);
        chk("tx_full_nopulse", tx_buf_en, 0);
        axi_rd(4'h8, d); chk("tx_drop", d[4], 1); chk("tx_full_st", d[2], 1);
        tx_buf_full = 0;
        axi_wr(4'hC, 32'h2, 4'hF);
        axi_rd(4'h8, d); chk("tx_drop_clr", d[4], 0);

        // read backpressure
        rx_byte(8'h77);
        s_axi_rready = 0;
        @(negedge clk_rx); s_axi_araddr = 4'h8; s_axi_arvalid = 1;
        @(negedge clk_rx); d0 = s_axi_rdata;
        chk("bp_val", d0, 32'h101);
        repeat (5) begin
            @(negedge clk_rx); #1;
            chk("bp_rvalid", s_axi_rvalid, 1);
            chk("bp_rdata", s_axi_rdata, d0);
            chk("bp_arready", s_axi_arready, 0);
        end
        s_axi_arvalid = 0; s_axi_rready = 1;
        axi_rd(4'h0, d); chk("bp_drain", d, 32'h177);

        // irq
        axi_wr(4'hC, 32'h8, 4'hF);
        axi_rd(4'hC, d); chk("irq_en_rd", d, 32'h8);
        rx_byte(8'h33);
        chk("irq_lat", irq, 0);
        @(negedge clk_rx); chk("irq_set", irq, 1);
        axi_rd(4'h0, d); chk("irq_pop", d, 32'h133);
        @(negedge clk_rx); chk("irq_clr", irq, 0);
        axi_wr(4'hC, 32'h0, 4'hF);

        // reset mid-transaction
        rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03);
        s_axi_bready = 0;
        axi_wr(4'h8, 32'h0, 4'hF);
        chk("mid_bvalid_pre", s_axi_bvalid, 1);
        #3 rst_clk_rx_n = 0;
        #1;
        chk("mid_bvalid", s_axi_bvalid, 0);
        chk("mid_rvalid", s_axi_rvalid, 0);
        @(negedge clk_rx);
        rst_clk_rx_n = 1; s_axi_bready = 1;
        axi_rd(4'h8, d); chk("mid_status", d, 32'h0);

        // random traffic
        repeat (3000) begin
            @(negedge clk_rx);
            s_axi_awvalid = 1'($urandom_range(0, 1));
            s_axi_wvalid  = 1'($urandom_range(0, 1));
            s_axi_awaddr  = 4'($urandom_range(0, 15));
            s_axi_wdata   = $urandom;
            s_axi_wstrb   = 4'($urandom_range(0, 15));
            s_axi_bready  = ($urandom_range(0, 3) != 0);
            s_axi_arvalid = 1'($urandom_range(0, 1));
            s_axi_araddr  = 4'($urandom_range(0, 15));
            s_axi_rready  = ($urandom_range(0, 3) != 0);
            rx_buf_rdy    = ($urandom_range(0, 2) != 0);
            rx_data       = 8'($urandom);
            tx_buf_full   = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk_rx);
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        s_axi_bready = 1; s_axi_rready = 1; rx_buf_rdy = 0; tx_buf_full = 0;
        repeat (4) @(negedge clk_rx);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bt_axi_host_if.md
Name: bt_axi_host_if

Overview:
- AXI4-Lite slave that forms the host end of the Bluetooth UART byte interface (rx_data/rx_buf_rdy in, tx_data/tx_buf_en/tx_buf_full out).
- Buffers received bytes in a small RX FIFO, turns register writes into single-cycle TX FIFO pushes, and reports sticky overrun/drop status and a level interrupt.
- Runs entirely in the clk_rx domain, which is also the TX character FIFO write clock.

Parameters:
RX_DEPTH, 16, RX FIFO depth in bytes; power of two, 2..256.
CNT_W, 5, count width; must equal log2(RX_DEPTH)+1.

Ports:
clk_rx  in  1  system clock (receive-domain clock)
rst_clk_rx_n  in  1  asynchronous active-low reset
s_axi_awaddr / s_axi_awvalid / s_axi_awready  in/in/out  4/1/1  write address channel
s_axi_wdata / s_axi_wstrb / s_axi_wvalid / s_axi_wready  in/in/in/out  32/4/1/1  write data channel
s_axi_bresp / s_axi_bvalid / s_axi_bready  out/out/in  2/1/1  write response
s_axi_araddr / s_axi_arvalid / s_axi_arready  in/in/out  4/1/1  read address
s_axi_rdata / s_axi_rresp / s_axi_rvalid / s_axi_rready  out/out/out/in  32/2/1/1  read data
rx_data  in  8  received byte, valid when rx_buf_rdy=1
rx_buf_rdy  in  1  one-cycle strobe: new byte present
tx_data  out  8  byte to TX character FIFO
tx_buf_en  out  1  one-cycle push to TX character FIFO
tx_buf_full  in  1  TX character FIFO full
irq  out  1  level interrupt

Behaviour:
- Reset (rst_clk_rx_n=0, asynchronous): all ready/valid outputs 0; rdata=0; bresp=rresp=0; tx_data=0; tx_buf_en=0; irq=0; RX FIFO empty; sticky bits and irq_en cleared.
- Register map (addr[3:2]):
  - 0x0 RX_DATA (RO): [7:0]=head byte, [8]=valid.
  - 0x4 TX_DATA (WO): reads return 0.
  - 0x8 STATUS (RO): [0]=rx_nonempty, [1]=rx_full, [2]=tx_buf_full, [3]=rx_overrun, [4]=tx_drop, [8+:CNT_W]=rx_count.
  - 0xC CTRL:
    - [0] W1: clear rx_overrun.
    - [1] W1: clear tx_drop.
    - [2] W1: flush RX FIFO.
    - [3] R/W: irq_en.
    - Reads return only [3].
  - addr[1:0] ignored. bresp/rresp always OKAY (00).
- Write channel:
  - Handshake completes only when awvalid=1, wvalid=1 and bvalid=0.
  - On that cycle awready=wready=1 for exactly one cycle.
  - bvalid=1 the next cycle and is held until bready=1.
- Read channel:
  - arready=1 whenever rvalid=0.
  - On the arvalid&arready cycle, rdata is registered; rvalid=1 the next cycle and is held, with rdata stable, until rready=1.
- RX_DATA read with FIFO non-empty: returns {23'b0,1,head}; the FIFO pops on the ar handshake cycle.
- RX_DATA read with FIFO empty: returns 0; no pop.
- RX push:
  - rx_buf_rdy=1 with count<RX_DEPTH: the byte is written.
  - rx_buf_rdy=1 with count==RX_DEPTH: the byte is discarded and rx_overrun is set.
  - Push and pop in the same cycle while full: both are performed, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: the pop is not performed (read returns 0) and the push lands.
- Flush:
  - Sets count=0 on the write handshake cycle.
  - Flush beats a same-cycle pop and a same-cycle push; the pushed byte is lost and no overrun is flagged.
- TX_DATA write:
  - wstrb[0]=0: no effect.
  - wstrb[0]=1 and tx_buf_full=0 on the handshake cycle: tx_data<=wdata[7:0] and tx_buf_en=1 for exactly the next cycle.
  - wstrb[0]=1 and tx_buf_full=1: no push; tx_drop is set.
  - Minimum spacing between pushes is 2 cycles, because a new write is blocked while bvalid=1.
- Sticky bits: a clear and a set in the same cycle leave the bit set.
- irq = irq_en & rx_nonempty, registered with 1-cycle latency.
- Pointers wrap modulo RX_DEPTH. Count is CNT_W bits and saturates logically at RX_DEPTH.

Test Plan:
- Reset mid-transaction: assert rst_clk_rx_n=0 while bvalid=1 and FIFO count=3 -> bvalid, rvalid and count all 0 immediately; STATUS read after release = 0x0.
- RX path: strobe bytes 0x41, 0x42, then read 0x0 three times -> 0x141, 0x142, 0x000; STATUS rx_count goes 2 -> 0.
- Overrun: 17 strobes (0x00..0x10) with RX_DEPTH=16 -> STATUS[1]=1, STATUS[3]=1, 16 reads return 0x100..0x10F. Write CTRL=0x1 -> STATUS[3]=0.
- Full simultaneous push/pop: FIFO full, read 0x0 in the same cycle as rx_buf_rdy=1 with 0x55 -> no overrun, count stays 16, 0x55 is the last byte out.
- TX path: write 0x4 data 0x5A, wstrb=0xF, tx_buf_full=0 -> tx_data=0x5A and tx_buf_en high for exactly 1 cycle after the handshake. Repeat with tx_buf_full=1 -> no tx_buf_en pulse, STATUS[4]=1; write CTRL=0x2 clears it.
- Backpressure/irq: hold rready=0 for 5 cycles -> rvalid and rdata stable, arready=0. Write CTRL=0x8, then strobe 1 byte -> irq=1 one cycle later; read RX_DATA -> irq=0.
